// File: rtl/bounce_counter_n.sv
// Parametrised up/down/bounce counter with runtime bounds, step, load, pause and a
// registered one-cycle terminal pulse. Bounce reversal never overshoots a bound.
module bounce_counter_n #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned STEP_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        mode,
   input  logic              pause,
   input  logic              load,
   input  logic [WIDTH-1:0]  ld_val,
   input  logic [WIDTH-1:0]  lo,
   input  logic [WIDTH-1:0]  hi,
   input  logic [STEP_W-1:0] step,
   output logic [WIDTH-1:0]  q,
   output logic              dir,
   output logic              tc
);

   localparam logic [1:0] ModeUp     = 2'b00;
   localparam logic [1:0] ModeDown   = 2'b01;
   localparam logic [1:0] ModeBounce = 2'b10;
   localparam logic [1:0] ModeHold   = 2'b11;

   // One extra bit so sums and differences never wrap.
   logic [WIDTH:0] q_x, lo_x, hi_x, s_x;
   logic [WIDTH:0] nxt_x;
   logic           clip_up, clip_dn, span_lt_s;
   logic [WIDTH-1:0] q_d;
   logic           dir_d, tc_d;

   assign q_x  = {1'b0, q};
   assign lo_x = {1'b0, lo};
   assign hi_x = {1'b0, hi};
   assign s_x  = (WIDTH + 1)'(step);

   assign clip_up   = (hi_x - q_x) < s_x;
   assign clip_dn   = (q_x - lo_x) < s_x;
   assign span_lt_s = (hi_x - lo_x) < s_x;

   always_comb begin
      nxt_x = q_x;
      dir_d = dir;
      tc_d  = 1'b0;
      if (load) begin
         nxt_x = {1'b0, ld_val};
         if (mode == ModeBounce) dir_d = 1'b0;
      end else if (pause || mode == ModeHold) begin
         nxt_x = q_x;
      end else if (lo > hi) begin
         nxt_x = q_x;
      end else if (q < lo || q > hi) begin
         nxt_x = lo_x;
         dir_d = 1'b0;
      end else if (step == '0) begin
         nxt_x = q_x;
      end else begin
         unique case (mode)
            ModeUp: begin
               dir_d = 1'b0;
               if (q == hi) begin
                  nxt_x = lo_x;
                  tc_d  = 1'b1;
               end else if (clip_up) begin
                  nxt_x = hi_x;
               end else begin
                  nxt_x = q_x + s_x;
               end
            end
            ModeDown: begin
               dir_d = 1'b1;
               if (q == lo) begin
                  nxt_x = hi_x;
                  tc_d  = 1'b1;
               end else if (clip_dn) begin
                  nxt_x = lo_x;
               end else begin
                  nxt_x = q_x - s_x;
               end
            end
            default: begin
               // Bounce; lo==hi falls out naturally as a toggle at lo.
               if (!dir) begin
                  if (q == hi) begin
                     dir_d = 1'b1;
                     tc_d  = 1'b1;
                     nxt_x = span_lt_s ? lo_x : hi_x - s_x;
                  end else begin
                     nxt_x = clip_up ? hi_x : q_x + s_x;
                  end
               end else begin
                  if (q == lo) begin
                     dir_d = 1'b0;
                     tc_d  = 1'b1;
                     nxt_x = span_lt_s ? hi_x : lo_x + s_x;
                  end else begin
                     nxt_x = clip_dn ? lo_x : q_x - s_x;
                  end
               end
            end
         endcase
      end
   end

   assign q_d = nxt_x[WIDTH-1:0];

   always_ff @(posedge clk) begin
      if (!rst) begin
         q   <= '0;
         dir <= 1'b0;
         tc  <= 1'b0;
      end else begin
         q   <= q_d;
         dir <= dir_d;
         tc  <= tc_d;
      end
   end

endmodule
